// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// The requester count and select width are fixed at 8 and 3.
package mux_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_8_to_1.sv
// Plain 1-bit 8:1 multiplexer shared by all requesters.
module mux_8_to_1 (
    input  logic [7:0] a,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = a[sel];

endmodule

// File: rtl/mux_rr_arbiter_rr_pick8.sv
// Combinational wrap-around priority finder: first set request bit
// strictly after last_ptr, wrapping from 7 back to 0.
module rr_pick8
    import mux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    // rot[k] is the request that sits k+1 places after last_ptr
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] offset;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [SEL_W-1:0] src;
            assign src     = last_ptr + SEL_W'(gi + 1);
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) offset = SEL_W'(k);
        end
    end

    assign any = |req;
    assign idx = last_ptr + SEL_W'(1) + offset;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 requesters, with bounded
// bursts, a dead cycle after every grant, and a registered, qualified output.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             out,
    output logic             out_valid
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] last_ptr_reg, last_ptr_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic             out_reg, out_valid_reg;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             mux_y;
    logic             burst_done;

    rr_pick8 u_pick (
        .req      (req),
        .last_ptr (last_ptr_reg),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    mux_8_to_1 u_mux (
        .a   (data_in),
        .sel (sel_reg),
        .y   (mux_y)
    );

    // The grant ends on a dropped request or a full burst, whichever first.
    assign burst_done = !req[sel_reg] || (cnt_reg == CNT_W'(BURST_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            last_ptr_reg  <= SEL_W'(N_REQ - 1);
            gnt_reg       <= '0;
            out_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            last_ptr_reg  <= last_ptr_next;
            gnt_reg       <= gnt_next;
            out_reg       <= busy ? mux_y : out_reg;
            out_valid_reg <= busy;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_any)   state_next = BUSY;
            BUSY:    if (burst_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Leaving BUSY always passes through IDLE, which provides the dead cycle.
    always_comb begin
        cnt_next      = cnt_reg;
        sel_next      = sel_reg;
        last_ptr_next = last_ptr_reg;
        gnt_next      = gnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    gnt_next = onehot(pick_idx);
                    sel_next = pick_idx;
                    cnt_next = CNT_W'(1);
                end
            end
            BUSY: begin
                if (burst_done) begin
                    gnt_next      = '0;
                    last_ptr_next = sel_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: gnt_next = '0;
        endcase
    end

    assign gnt       = gnt_reg;
    assign sel       = sel_reg;
    assign busy      = |gnt_reg;
    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios against fixed
// expectations, then random traffic against a cycle-level behavioural model.
module tb_mux_rr_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit         m_busy;
    int         m_owner;
    int         m_cnt;
    int         m_last;
    logic [7:0] m_gnt;
    logic [2:0] m_sel;
    logic       m_out;
    logic       m_valid;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.BURST_LEN(BURST), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .sel       (sel),
        .busy      (busy),
        .out       (out),
        .out_valid (out_valid)
    );

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 7;
        m_gnt   = 8'h00;
        m_sel   = 3'd0;
        m_out   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic [7:0] d);
        m_valid = (m_gnt != 8'h00);
        if (m_gnt != 8'h00) m_out = d[m_sel];
        if (m_busy) begin
            if (!r[m_owner] || m_cnt == BURST) begin
                m_gnt  = 8'h00;
                m_last = m_owner;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end else if (r != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
                int i;
                i = (m_last + k) % 8;
                if (r[i]) begin
                    m_owner = i;
                    break;
                end
            end
            m_gnt  = 8'(1 << m_owner);
            m_sel  = 3'(m_owner);
            m_cnt  = 1;
            m_busy = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(req, data_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        data_in = 8'h00;
        #3;
        checks++;
        if ({gnt, sel, busy, out, out_valid} !== 14'd0) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", {gnt, sel, busy, out, out_valid}, 14'd0);
        end
        rst = 1'b0;
        model_reset();
        tick();
        req = 8'h08;
        tick();
        tick();
        checks++;
        if (gnt !== 8'h08 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_grant: got gnt=%h ov=%b required gnt=08 ov=1", gnt, out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%h busy=%b ov=%b required 00/0/0", gnt, busy, out_valid);
        end
        rst = 1'b0;
        model_reset();
        req = 8'h09;
        tick();
        checks++;
        if (gnt !== 8'h01) begin
            errors++;
            $display("FAIL reset_restart: got gnt=%h required 01", gnt);
        end
    endtask

    task automatic test_single_held();
        do_reset();
        req = 8'h08;
        for (int t = 0; t < 15; t++) begin
            logic [7:0] exp_gnt;
            tick();
            exp_gnt = (t % 5 == 4) ? 8'h00 : 8'h08;
            checks++;
            if (gnt !== exp_gnt || (exp_gnt != 8'h00 && sel !== 3'd3)) begin
                errors++;
                $display("FAIL single_held t=%0d: got gnt=%h sel=%0d required gnt=%h sel=3", t, gnt, sel, exp_gnt);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_all_req();
        do_reset();
        req = 8'hFF;
        for (int t = 0; t < 45; t++) begin
            logic [7:0] exp_gnt;
            tick();
            exp_gnt = (t % 5 == 4) ? 8'h00 : 8'(1 << ((t / 5) % 8));
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL all_req t=%0d: got gnt=%h required %h", t, gnt, exp_gnt);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [0:10];
        exp_seq = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00,
                    8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h40};
        do_reset();
        req = 8'h40;
        for (int t = 0; t < 11; t++) begin
            if (t == 4) req = 8'h41;
            tick();
            checks++;
            if (gnt !== exp_seq[t]) begin
                errors++;
                $display("FAIL wrap t=%0d: got gnt=%h required %h", t, gnt, exp_seq[t]);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_early_release();
        do_reset();
        req = 8'h20;
        for (int t = 0; t < 8; t++) begin
            logic [7:0] exp_gnt;
            logic       exp_ov;
            if (t == 3) req = 8'h00;
            tick();
            exp_gnt = (t < 3) ? 8'h20 : 8'h00;
            exp_ov  = (t >= 1 && t <= 3);
            checks++;
            if (gnt !== exp_gnt || out_valid !== exp_ov) begin
                errors++;
                $display("FAIL early_release t=%0d: got gnt=%h ov=%b required gnt=%h ov=%b",
                         t, gnt, out_valid, exp_gnt, exp_ov);
            end
        end
    endtask

    task automatic test_datapath();
        do_reset();
        data_in = 8'hA5;
        req = 8'h04;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 1'b1) begin
            errors++;
            $display("FAIL data_req2: got out=%b ov=%b required out=1 ov=1", out, out_valid);
        end
        req = 8'h00;
        tick();
        data_in = 8'h00;
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (gnt !== 8'h00 || out_valid !== 1'b0 || out !== 1'b1 || sel !== 3'd2) begin
            errors++;
            $display("FAIL idle_hold_2: got gnt=%h ov=%b out=%b sel=%0d required 00/0/1/2", gnt, out_valid, out, sel);
        end
        data_in = 8'hA5;
        req = 8'h02;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 1'b0 || gnt !== 8'h02) begin
            errors++;
            $display("FAIL data_req1: got out=%b ov=%b gnt=%h required out=0 ov=1 gnt=02", out, out_valid, gnt);
        end
        req = 8'h00;
        tick();
        data_in = 8'hFF;
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (out_valid !== 1'b0 || out !== 1'b0 || sel !== 3'd1) begin
            errors++;
            $display("FAIL idle_hold_1: got ov=%b out=%b sel=%0d required 0/0/1", out_valid, out, sel);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            req     = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            data_in = 8'($urandom);
            tick();
            checks++;
            if ({gnt, sel, busy, out, out_valid} !== {m_gnt, m_sel, (m_gnt != 8'h00), m_out, m_valid}) begin
                errors++;
                $display("FAIL random t=%0d: got gnt=%h sel=%0d busy=%b out=%b ov=%b required gnt=%h sel=%0d out=%b ov=%b",
                         t, gnt, sel, busy, out, out_valid, m_gnt, m_sel, m_out, m_valid);
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1;
                checks++;
                if (gnt !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL random_reset t=%0d: got gnt=%h busy=%b ov=%b required 00/0/0", t, gnt, busy, out_valid);
                end
                rst = 1'b0;
                model_reset();
            end
        end
        req = 8'h00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_held();
        test_all_req();
        test_wrap();
        test_early_release();
        test_datapath();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 1-bit 8:1 mux datapath among 8 requesters. It picks one requester, drives the 3-bit mux select and a one-hot grant, and holds the grant for a bounded burst. After every grant it inserts one dead cycle, so any tristate-based mux stage never sees two drivers enabled at once. The mux output is registered and qualified by a valid flag for the downstream consumer.

Parameters:
BURST_LEN, 4, maximum consecutive grant cycles per winner; legal range 1..15
CNT_W, 4, burst counter width; fixed, must satisfy BURST_LEN <= 2**CNT_W - 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  8  request lines; req[i] is held high while requester i wants the mux
data_in  input  8  mux data inputs; data_in[i] belongs to requester i
gnt  output  8  one-hot grant; all-zero when no grant; registered
sel  output  3  mux select = index of the current or last grantee; registered
busy  output  1  high while a grant is active (gnt != 0)
out  output  1  registered data_in[sel], sampled while granted
out_valid  output  1  high on the cycle after each gnt-high cycle

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. All state clears immediately on rst, independent of clk.
- Reset values: state=IDLE, gnt=8'h00, sel=3'd0, busy=0, out=0, out_valid=0, cnt=0, last_ptr=3'd7 (so requester 0 has top priority after reset).
- Two-state FSM: IDLE and BUSY. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE. gnt stays 0 and sel holds its value (no select toggling while idle).
  - Else choose winner w = first set bit of req, scanning from (last_ptr+1) mod 8 upward and wrapping past 7 to 0.
  - At the next edge: gnt=1<<w, sel=w, cnt=1, state=BUSY.
  - Latency from req sampled high (with the arbiter in IDLE) to gnt high: 1 cycle.
- BUSY (each edge):
  - If req[sel]==0 or cnt==BURST_LEN, then gnt=0, last_ptr=sel, state=IDLE.
  - Otherwise cnt=cnt+1 and the grant is held.
  - req[sel] is sampled at the edge, so gnt stays high one trailing cycle after the requester drops req. The requester must ignore that cycle.
  - Requests from other requesters never preempt the current grant.
- Grant timing:
  - A held request gets exactly BURST_LEN consecutive gnt-high cycles.
  - Between any two grants, gnt=0 for at least 1 cycle, even when the same requester is re-granted.
- Fairness: last_ptr updates only when a grant ends. A requester that holds req waits at most 7 other bursts before it is granted.
- Datapath: each edge, out <= data_in[sel] and out_valid <= busy.
  - out holds its value when out_valid=0.
  - out_valid therefore lags gnt by exactly 1 cycle.
- busy is exactly the OR-reduction of gnt.
- Reset mid-burst: gnt, busy and out_valid drop immediately and asynchronously. After rst releases, arbitration restarts from last_ptr=7.
- A req bit asserted and deasserted within a single cycle while the arbiter is BUSY is not seen. No request latching is done.

Decomposition:
- Shared package/include: constants for N_REQ=8, SEL_W=3, and the state encodings IDLE=1'b0, BUSY=1'b1.
- One natural sub-module: rr_pick8, a combinational wrap-around priority finder.
  - Inputs: req[7:0], last_ptr[2:0].
  - Outputs: any, idx[2:0].
- The FSM, counter and output registers stay in mux_rr_arbiter.
- The datapath select uses the existing mux_8_to_1, instantiated with a=data_in and sel=sel. Its output feeds the out register.

Test Plan:
- Reset mid-burst: grant req=8'h08, assert rst on the 2nd gnt cycle. Expect gnt=00, busy=0, out_valid=0 immediately. After release with req=8'h09, the first grant is gnt=01 (last_ptr back to 7).
- Single held requester: req=8'h08 constant. Expect gnt=08 and sel=3 one cycle later, held for 4 cycles, then 1 cycle of 00, then 08 again for 4 cycles, repeating.
- All requesting: req=8'hFF constant. Expect grant order 01,02,04,...,80,01, each lasting 4 cycles with a 1-cycle 00 gap between grants.
- Wrap-around: last_ptr=6 (after a requester-6 burst) and req=8'h41. Expect next gnt=01, then 40.
- Early release: req=8'h20, dropped after the 2nd gnt cycle. Expect gnt=20 for exactly 3 cycles, out_valid high for 3 cycles starting one cycle after gnt, then IDLE.
- Datapath: data_in=8'hA5.
  - Grant requester 2: out=1 with out_valid=1 one cycle after gnt.
  - Grant requester 1: out=0.
  - While idle, out holds its last value and sel holds its last value.
